// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported unified instruction/data memory
//               between IF-stage fetch and MEM-stage load/store. One requester
//               wins each access. The block drives the 2:1 address/data mux
//               select and runs the memory handshake with a response timeout.
//               The winner gets a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   if_req/if_addr               fetch request and address
//   if_done/if_rdata             fetch completion pulse, registered fetch word
//   d_req/d_we/d_addr/d_wdata    data request, store enable, address, data
//   d_done/d_rdata               data completion pulse, registered load data
//   mem_req/mem_we               memory strobe (held until mem_ready), write
//   mem_addr/mem_wdata           registered winner address / store data
//   mem_ready/mem_rdata          memory completion and read data
//   addr_sel                     mux select: 0 = fetch path, 1 = data path
//   bus_err                      pulses with done when an access timed out
// ============================================================================
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 3,
  parameter int TIMEOUT    = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          addr_sel,
  output logic          bus_err
);

  localparam int C_TW = $clog2(TIMEOUT + 1);
  localparam int C_SW = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
  localparam logic [C_TW-1:0] C_TMO_LAST  = C_TW'(TIMEOUT - 1);
  localparam logic [C_SW-1:0] C_STARVE_MX = C_SW'(MAX_STARVE);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t          r_state,     w_state_nxt;
  logic            r_mem_req,   w_mem_req_nxt;
  logic            r_mem_we,    w_mem_we_nxt;
  logic [AW-1:0]   r_mem_addr,  w_mem_addr_nxt;
  logic [DW-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic            r_addr_sel,  w_addr_sel_nxt;
  logic [DW-1:0]   r_if_rdata,  w_if_rdata_nxt;
  logic [DW-1:0]   r_d_rdata,   w_d_rdata_nxt;
  logic            r_if_done,   w_if_done_nxt;
  logic            r_d_done,    w_d_done_nxt;
  logic            r_bus_err,   w_bus_err_nxt;
  logic [C_SW-1:0] r_starve,    w_starve_nxt;
  logic [C_TW-1:0] r_tmo,       w_tmo_nxt;
  logic            w_grant_d;

  // Data normally wins a tie; fetch wins once it has been passed over
  // MAX_STARVE times in a row.
  assign w_grant_d = d_req & ~(if_req & (r_starve == C_STARVE_MX));

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_addr_sel_nxt  = r_addr_sel;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_if_done_nxt   = 1'b0;
    w_d_done_nxt    = 1'b0;
    w_bus_err_nxt   = 1'b0;
    w_starve_nxt    = r_starve;
    w_tmo_nxt       = r_tmo;

    case (r_state)
      ST_IDLE: begin
        if (!if_req) begin
          w_starve_nxt = '0;
        end
        if (if_req || d_req) begin
          w_state_nxt    = ST_ACCESS;
          w_mem_req_nxt  = 1'b1;
          w_addr_sel_nxt = w_grant_d;
          w_tmo_nxt      = '0;
          if (w_grant_d) begin
            w_mem_addr_nxt  = d_addr;
            w_mem_we_nxt    = d_we;
            w_mem_wdata_nxt = d_wdata;
            // Count only grants that actually made fetch wait.
            if (if_req && (r_starve != C_STARVE_MX)) begin
              w_starve_nxt = r_starve + 1'b1;
            end
          end else begin
            w_mem_addr_nxt  = if_addr;
            w_mem_we_nxt    = 1'b0;
            w_mem_wdata_nxt = '0;
            w_starve_nxt    = '0;
          end
        end
      end

      ST_ACCESS: begin
        w_tmo_nxt = r_tmo + 1'b1;
        // mem_ready takes priority over an expiring timeout.
        if (mem_ready) begin
          w_state_nxt   = ST_RESP;
          w_mem_req_nxt = 1'b0;
          if (r_addr_sel) begin
            w_d_rdata_nxt = mem_rdata;
            w_d_done_nxt  = 1'b1;
          end else begin
            w_if_rdata_nxt = mem_rdata;
            w_if_done_nxt  = 1'b1;
          end
        end else if (r_tmo == C_TMO_LAST) begin
          w_state_nxt   = ST_RESP;
          w_mem_req_nxt = 1'b0;
          w_bus_err_nxt = 1'b1;
          if (r_addr_sel) begin
            w_d_rdata_nxt = '0;
            w_d_done_nxt  = 1'b1;
          end else begin
            w_if_rdata_nxt = '0;
            w_if_done_nxt  = 1'b1;
          end
        end
      end

      // The done pulse is visible during this single cycle; requests are
      // deliberately ignored so a held req cannot start a duplicate access.
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_addr_sel  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_done   <= 1'b0;
      r_d_done    <= 1'b0;
      r_bus_err   <= 1'b0;
      r_starve    <= '0;
      r_tmo       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_addr_sel  <= w_addr_sel_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_if_done   <= w_if_done_nxt;
      r_d_done    <= w_d_done_nxt;
      r_bus_err   <= w_bus_err_nxt;
      r_starve    <= w_starve_nxt;
      r_tmo       <= w_tmo_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign addr_sel  = r_addr_sel;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign if_done   = r_if_done;
  assign d_done    = r_d_done;
  assign bus_err   = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. The two requesters
//               and the memory are modelled one transaction at a time, and
//               the expected grant, bus values and results come from a
//               transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int MAX_STARVE = 3;
  localparam int TIMEOUT    = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, d_req, d_we, mem_ready;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          if_done, d_done, mem_req, mem_we, addr_sel, bus_err;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int total = 0;
  int bad   = 0;
  int starve_ref = 0;            // reference count of fetch-waiting data grants
  logic [DW-1:0] next_rd = 32'h0;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .addr_sel(addr_sel), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic new_fetch();
    if_req  = 1'b1;
    if_addr = {$urandom} & 32'hFFFF_FFFC;
  endtask

  task automatic new_data();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = {$urandom} & 32'hFFFF_FFFC;
    d_wdata = $urandom;
  endtask

  // One access from grant to the IDLE cycle after done.
  // k    : ACCESS cycle in which mem_ready is given (0 = never, times out)
  // rmid : pulse reset during ACCESS cycle k instead of completing
  // autor: randomly re-request on the winner's side after done
  task automatic do_txn(input int k, input bit rmid, input bit autor);
    bit            win_d;
    bit            got_ready;
    bit            exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    logic [DW-1:0] rd;
    int            n;
    rd = 32'h0;
    if (!if_req && !d_req) begin
      n = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        check_val("idle_quiet", {mem_req, if_done, d_done, bus_err}, 4'b0000);
      end
      starve_ref = 0;
      n = $urandom_range(1, 3);
      if (n[0]) new_fetch();
      if (n[1]) new_data();
    end

    // Reference arbitration: data wins a tie unless fetch has already waited
    // MAX_STARVE consecutive data grants.
    win_d = d_req && !(if_req && starve_ref == MAX_STARVE);
    if (!if_req || !win_d) starve_ref = 0;
    else if (starve_ref < MAX_STARVE) starve_ref = starve_ref + 1;
    exp_addr = win_d ? d_addr  : if_addr;
    exp_we   = win_d ? d_we    : 1'b0;
    exp_wd   = win_d ? d_wdata : 32'h0;

    @(posedge clk); #1;
    check_val("grant_req",   {mem_req, if_done, d_done}, 3'b100);
    check_val("grant_sel",   addr_sel,  win_d);
    check_val("grant_addr",  mem_addr,  exp_addr);
    check_val("grant_we",    mem_we,    exp_we);
    check_val("grant_wdata", mem_wdata, exp_wd);

    for (int c = 1; c <= TIMEOUT; c++) begin
      if (rmid && c == k) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_val("rst_ctl", {mem_req, addr_sel, if_done, d_done, bus_err}, 5'b0);
        check_val("rst_rdata", {if_rdata, d_rdata}, 64'h0);
        starve_ref = 0;
        return;
      end
      if (c == k) begin
        rd        = next_rd;
        next_rd   = $urandom;
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      if (c == k || c == TIMEOUT) break;
      check_val("access_hold", {mem_req, if_done, d_done, bus_err}, 4'b1000);
      check_val("access_addr", mem_addr, exp_addr);
    end

    got_ready = (k >= 1 && k <= TIMEOUT);
    check_val("done_pair", {if_done, d_done}, win_d ? 2'b01 : 2'b10);
    check_val("done_err",  bus_err, !got_ready);
    check_val("done_mreq", mem_req, 1'b0);
    check_val("done_sel",  addr_sel, win_d);
    if (!win_d)
      check_val("if_rdata", if_rdata, got_ready ? rd : 32'h0);
    else if (!exp_we || !got_ready)
      check_val("d_rdata", d_rdata, got_ready ? rd : 32'h0);

    // Winner drops or re-requests during RESP; loser keeps its request high.
    if (win_d) begin
      d_req = 1'b0;
      if (autor && $urandom_range(0, 3) != 0) new_data();
    end else begin
      if_req = 1'b0;
      if (autor && $urandom_range(0, 3) != 0) new_fetch();
    end
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check_val("resp_after", {mem_req, if_done, d_done, bus_err}, 4'b0000);
    check_val("resp_sel",   addr_sel, win_d);
  endtask

  initial begin
    int r;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("reset_ctl", {mem_req, mem_we, addr_sel, if_done, d_done, bus_err}, 6'b0);
    check_val("reset_bus", {mem_addr, mem_wdata}, 64'h0);
    check_val("reset_rd",  {if_rdata, d_rdata}, 64'h0);

    // Fetch only, memory answers in the second ACCESS cycle.
    if_req = 1'b1; if_addr = 32'h40; next_rd = 32'h0050_0093;
    do_txn(2, 1'b0, 1'b0);

    // Simultaneous store and fetch: store first, then the fetch.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h44;
    do_txn(1, 1'b0, 1'b0);
    do_txn(3, 1'b0, 1'b0);

    // Starvation: fetch held, data re-requested after every grant.
    if_req = 1'b1; if_addr = 32'h80;
    for (int i = 0; i < 8; i++) begin
      if (!d_req) begin
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200 + 32'(i * 4); d_wdata = $urandom;
      end
      if (!if_req) begin
        if_req = 1'b1; if_addr = 32'h80 + 32'(i * 4);
      end
      do_txn(1, 1'b0, 1'b0);
    end
    if_req = 1'b0; d_req = 1'b0;

    // Timeout on a load, then mem_ready arriving in the last allowed cycle.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_wdata = 32'h0;
    do_txn(0, 1'b0, 1'b0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h304;
    next_rd = 32'hCAFE_F00D;
    do_txn(TIMEOUT, 1'b0, 1'b0);

    // Reset during ACCESS, then the held fetch completes normally.
    if_req = 1'b1; if_addr = 32'h48;
    do_txn(2, 1'b1, 1'b0);
    do_txn(2, 1'b0, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      do_txn($urandom_range(1, 4), 1'b0, 1'b1);
      else if (r < 88) do_txn(0, 1'b0, 1'b1);
      else if (r < 94) do_txn(TIMEOUT, 1'b0, 1'b1);
      else             do_txn($urandom_range(1, 3), 1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
